// File: rtl/max7219_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module      : max7219_frame_feeder
// Description : Shadow digit store for a MAX7219. After reset it emits the chip
//               init words, then only the digits that changed, as (addr,data)
//               words on a valid/ready handshake. Optional periodic re-init is
//               enabled by defining MAX7219_REFRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module max7219_frame_feeder #(
    parameter int          DIGITS         = 8,
    parameter logic [3:0]  INTENSITY      = 4'hF,
    parameter logic [7:0]  DECODE         = 8'hFF,
    parameter logic [23:0] REFRESH_CYCLES = 24'd5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_digit,
    input  logic [7:0] wr_data,
    output logic       word_valid,
    output logic [7:0] word_addr,
    output logic [7:0] word_data,
    input  logic       word_ready,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_PTR  = 3'(DIGITS - 1);
    localparam logic [2:0] c_LAST_INIT = 3'd4;
    localparam logic [7:0] c_DIRTY_ALL = 8'((16'd1 << DIGITS) - 16'd1);

    state_t     r_state;
    logic [2:0] r_init_idx;
    logic [2:0] r_ptr;
    logic [7:0] r_dirty;
    logic [7:0] r_shadow [8];

    logic       w_wr_hit;
    logic [2:0] w_ptr_next;
    logic [7:0] w_dirty_set;
    logic [7:0] w_dirty_clr;
    logic       w_refresh_take;
    logic       w_latch;

    function automatic logic [15:0] init_word(input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {8'h0F, 8'h00};
            3'd1:    w = {8'h0C, 8'h01};
            3'd2:    w = {8'h0B, 8'(DIGITS - 1)};
            3'd3:    w = {8'h0A, 4'h0, INTENSITY};
            default: w = {8'h09, DECODE};
        endcase
        return w;
    endfunction

    assign w_wr_hit    = wr_en && (32'(wr_digit) < 32'(DIGITS));
    assign w_ptr_next  = (r_ptr == c_LAST_PTR) ? 3'd0 : r_ptr + 3'd1;
    assign w_latch     = (r_state == ST_SCAN) && !w_refresh_take && r_dirty[r_ptr];
    assign w_dirty_set = w_wr_hit ? (8'd1 << wr_digit) : 8'd0;
    // The dirty bit is dropped when the digit is latched for sending; any write
    // arriving from then until (and including) the transfer edge re-marks it,
    // so the newer value always goes out on a later pass.
    assign w_dirty_clr = w_latch ? (8'd1 << r_ptr) : 8'd0;

    assign busy = (r_state != ST_SCAN) | (|r_dirty) | word_valid;

`ifdef MAX7219_REFRESH_EN
    logic [23:0] r_refresh_cnt;
    logic        r_refresh_pend;
    logic        w_refresh_pulse;

    assign w_refresh_pulse = (r_refresh_cnt == REFRESH_CYCLES - 24'd1);
    assign w_refresh_take  = r_refresh_pend && (r_state == ST_SCAN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh_cnt  <= 24'd0;
            r_refresh_pend <= 1'b0;
        end else begin
            r_refresh_cnt <= w_refresh_pulse ? 24'd0 : r_refresh_cnt + 24'd1;
            if (w_refresh_take)
                r_refresh_pend <= 1'b0;
            else if (w_refresh_pulse && (r_state != ST_INIT))
                r_refresh_pend <= 1'b1;
        end
    end
`else
    logic w_unused_refresh;
    assign w_unused_refresh = ^REFRESH_CYCLES;
    assign w_refresh_take   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                r_shadow[i] <= 8'd0;
        end else if (w_wr_hit) begin
            r_shadow[wr_digit] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_idx <= 3'd0;
            r_ptr      <= 3'd0;
            r_dirty    <= c_DIRTY_ALL;
            word_valid <= 1'b0;
            word_addr  <= 8'd0;
            word_data  <= 8'd0;
            init_done  <= 1'b0;
        end else begin
            r_dirty <= w_refresh_take ? c_DIRTY_ALL
                                      : ((r_dirty & ~w_dirty_clr) | w_dirty_set);
            case (r_state)
                ST_INIT: begin
                    if (!word_valid) begin
                        {word_addr, word_data} <= init_word(r_init_idx);
                        word_valid             <= 1'b1;
                    end else if (word_ready) begin
                        if (r_init_idx == c_LAST_INIT) begin
                            word_valid <= 1'b0;
                            init_done  <= 1'b1;
                            r_init_idx <= 3'd0;
                            r_state    <= ST_SCAN;
                        end else begin
                            {word_addr, word_data} <= init_word(r_init_idx + 3'd1);
                            r_init_idx             <= r_init_idx + 3'd1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_refresh_take) begin
                        r_init_idx <= 3'd0;
                        r_state    <= ST_INIT;
                    end else if (r_dirty[r_ptr]) begin
                        word_addr  <= {5'd0, r_ptr} + 8'd1;
                        word_data  <= r_shadow[r_ptr];
                        word_valid <= 1'b1;
                        r_state    <= ST_SEND;
                    end else begin
                        r_ptr <= w_ptr_next;
                    end
                end
                ST_SEND: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        r_ptr      <= w_ptr_next;
                        r_state    <= ST_SCAN;
                    end
                end
                default: begin
                    word_valid <= 1'b0;
                    r_state    <= ST_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
